// File: rtl/rv32_types.sv
// Shared exec-stage types and constants for the RV32 core.
// Pure declarations, no logic, no latency, no flow control.
package rv32_types;

   localparam int RV_XLEN           = 32;
   localparam int FXMADD_LATENCY    = 3;
   localparam int FXMADD_NUM_SCALES = 8;
   localparam int FXMADD_SEL_W      = $clog2(FXMADD_NUM_SCALES);

   typedef struct packed {
      logic [RV_XLEN-1:0]      a;
      logic [RV_XLEN-1:0]      b;
      logic [RV_XLEN-1:0]      c;
      logic [FXMADD_SEL_W-1:0] sel;
      logic                    round_en;
      logic                    sat_en;
   } fxmadd_req_t;

endpackage

// File: rtl/rv32_fxmadd_scale_rf.sv
// Shift-scale register file: one write port, two combinational read ports, resets to scale[i]=i.
// Writes take effect at the clock edge; reads are zero latency; no backpressure.
module rv32_fxmadd_scale_rf #(
   parameter int NUM_SCALES = 8,
   parameter int SEL_W      = 3,
   parameter int SCALE_W    = 6
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               we_i,
   input  logic [SEL_W-1:0]   waddr_i,
   input  logic [SCALE_W-1:0] wdata_i,
   input  logic [SEL_W-1:0]   rd0_addr_i,
   output logic [SCALE_W-1:0] rd0_data_o,
   input  logic [SEL_W-1:0]   rd1_addr_i,
   output logic [SCALE_W-1:0] rd1_data_o
);

   logic [SCALE_W-1:0] scale_q [NUM_SCALES];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM_SCALES; i++) begin
            scale_q[i] <= SCALE_W'(i);
         end
      end else if (we_i) begin
         scale_q[waddr_i] <= wdata_i;
      end
   end

   assign rd0_data_o = scale_q[rd0_addr_i];
   assign rd1_data_o = scale_q[rd1_addr_i];

endmodule

// File: rtl/rv32_fxmadd_pipe.sv
// Pipelined fixed-point ((a*b) >>> scale[sel]) + c with optional rounding and saturation.
// Latency 3 cycles, 1 op/cycle; a stalled output freezes every stage and drops in_ready.
module rv32_fxmadd_pipe
   import rv32_types::*;
#(
   parameter int  XLEN       = RV_XLEN,
   parameter int  NUM_SCALES = FXMADD_NUM_SCALES,
   localparam int SEL_W      = $clog2(NUM_SCALES),
   localparam int SCALE_W    = $clog2(2*XLEN)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [XLEN-1:0]    mul_op_1,
   input  logic [XLEN-1:0]    mul_op_2,
   input  logic [XLEN-1:0]    add_op,
   input  logic [SEL_W-1:0]   scale_sel,
   input  logic               round_en,
   input  logic               sat_en,
   input  logic               scale_we,
   input  logic [SEL_W-1:0]   scale_addr,
   input  logic [SCALE_W-1:0] scale_wdata,
   output logic [SCALE_W-1:0] scale_rdata,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [XLEN-1:0]    result,
   output logic               overflow
);

   localparam int PW = 2*XLEN;
   localparam int SW = PW + 2;
   localparam logic signed [SW-1:0] SUM_MAX = {{(XLEN+3){1'b0}}, {(XLEN-1){1'b1}}};
   localparam logic signed [SW-1:0] SUM_MIN = {{(XLEN+3){1'b1}}, {(XLEN-1){1'b0}}};

   logic adv, accept;
   logic [SCALE_W-1:0] issue_scale;

   logic                    s1_vld_q, s1_round_q, s1_sat_q;
   logic [PW-1:0]           s1_prod_q, s1_prod_d;
   logic [XLEN-1:0]         s1_c_q;
   logic [SCALE_W-1:0]      s1_scale_q;

   logic                    s2_vld_q, s2_sat_q;
   logic signed [PW:0]      s2_shift_q, s2_shift_d, rnd_inc, rnd_sum;
   logic [XLEN-1:0]         s2_c_q;

   logic                    out_valid_q, overflow_q, overflow_d;
   logic [XLEN-1:0]         result_q, result_d;
   logic signed [SW-1:0]    sum_d;
   logic                    pos_ovf, neg_ovf;

   assign adv      = !out_valid_q || out_ready;
   assign in_ready = adv;
   assign accept   = in_valid && adv;

   // Read port 0 feeds issue, port 1 the readback; same-cycle writes land after capture.
   rv32_fxmadd_scale_rf #(
      .NUM_SCALES (NUM_SCALES),
      .SEL_W      (SEL_W),
      .SCALE_W    (SCALE_W)
   ) u_scale_rf (
      .clk        (clk),
      .rst        (rst),
      .we_i       (scale_we),
      .waddr_i    (scale_addr),
      .wdata_i    (scale_wdata),
      .rd0_addr_i (scale_sel),
      .rd0_data_o (issue_scale),
      .rd1_addr_i (scale_addr),
      .rd1_data_o (scale_rdata)
   );

   assign s1_prod_d = {{XLEN{mul_op_1[XLEN-1]}}, mul_op_1} * {{XLEN{mul_op_2[XLEN-1]}}, mul_op_2};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_vld_q   <= 1'b0;
         s1_prod_q  <= '0;
         s1_c_q     <= '0;
         s1_scale_q <= '0;
         s1_round_q <= 1'b0;
         s1_sat_q   <= 1'b0;
      end else if (adv) begin
         s1_vld_q <= accept;
         if (accept) begin
            s1_prod_q  <= s1_prod_d;
            s1_c_q     <= add_op;
            s1_scale_q <= issue_scale;
            s1_round_q <= round_en;
            s1_sat_q   <= sat_en;
         end
      end
   end

   // One extra bit keeps the round-half-up carry from wrapping the product.
   always_comb begin
      rnd_inc = '0;
      if (s1_round_q && (s1_scale_q != '0)) begin
         rnd_inc = (PW+1)'(1) << (s1_scale_q - SCALE_W'(1));
      end
      rnd_sum    = {s1_prod_q[PW-1], s1_prod_q} + rnd_inc;
      s2_shift_d = rnd_sum >>> s1_scale_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s2_vld_q   <= 1'b0;
         s2_shift_q <= '0;
         s2_c_q     <= '0;
         s2_sat_q   <= 1'b0;
      end else if (adv) begin
         s2_vld_q <= s1_vld_q;
         if (s1_vld_q) begin
            s2_shift_q <= s2_shift_d;
            s2_c_q     <= s1_c_q;
            s2_sat_q   <= s1_sat_q;
         end
      end
   end

   always_comb begin
      sum_d      = {s2_shift_q[PW], s2_shift_q} + {{(XLEN+2){s2_c_q[XLEN-1]}}, s2_c_q};
      pos_ovf    = sum_d > SUM_MAX;
      neg_ovf    = sum_d < SUM_MIN;
      overflow_d = pos_ovf || neg_ovf;
      result_d   = sum_d[XLEN-1:0];
      if (s2_sat_q && pos_ovf) begin
         result_d = {1'b0, {(XLEN-1){1'b1}}};
      end else if (s2_sat_q && neg_ovf) begin
         result_d = {1'b1, {(XLEN-1){1'b0}}};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         result_q    <= '0;
         overflow_q  <= 1'b0;
      end else if (adv) begin
         out_valid_q <= s2_vld_q;
         if (s2_vld_q) begin
            result_q   <= result_d;
            overflow_q <= overflow_d;
         end
      end
   end

   assign out_valid = out_valid_q;
   assign result    = result_q;
   assign overflow  = overflow_q;

endmodule

// File: tb/tb_rv32_fxmadd_pipe.sv
// Self-checking bench for rv32_fxmadd_pipe: directed scenarios plus randomized traffic
// against a wide-integer reference model and a result scoreboard.
module tb_rv32_fxmadd_pipe;
   import rv32_types::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0, in_ready;
   logic [31:0] mul_op_1 = '0, mul_op_2 = '0, add_op = '0;
   logic [2:0]  scale_sel = '0, scale_addr = '0;
   logic        round_en = 1'b0, sat_en = 1'b0, scale_we = 1'b0;
   logic [5:0]  scale_wdata = '0, scale_rdata;
   logic        out_valid, out_ready = 1'b1, overflow;
   logic [31:0] result;

   int tests = 0;
   int fails = 0;
   int mscale [8];

   rv32_fxmadd_pipe dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .mul_op_1(mul_op_1), .mul_op_2(mul_op_2), .add_op(add_op),
      .scale_sel(scale_sel), .round_en(round_en), .sat_en(sat_en),
      .scale_we(scale_we), .scale_addr(scale_addr), .scale_wdata(scale_wdata),
      .scale_rdata(scale_rdata), .out_valid(out_valid), .out_ready(out_ready),
      .result(result), .overflow(overflow)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Reference: exact integer arithmetic on wide values straight from the operation's definition.
   function automatic void model(input logic [31:0] a, b, c, input int s, input logic rnd, sat,
                                 output logic [31:0] r, output logic o);
      logic signed [127:0] p;
      p = 128'($signed(a)) * 128'($signed(b));
      if (rnd && s > 0) p = p + (128'sd1 <<< (s - 1));
      p = p >>> s;
      p = p + 128'($signed(c));
      o = (p > 128'sd2147483647) || (p < -128'sd2147483648);
      if (sat && o) r = (p > 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
      else          r = p[31:0];
   endfunction

   task automatic do_reset();
      in_valid = 1'b0; scale_we = 1'b0; out_ready = 1'b1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      for (int i = 0; i < 8; i++) mscale[i] = i;
      @(posedge clk); #1;
   endtask

   task automatic drive_op(input fxmadd_req_t q);
      mul_op_1 = q.a; mul_op_2 = q.b; add_op = q.c;
      scale_sel = q.sel; round_en = q.round_en; sat_en = q.sat_en;
   endtask

   task automatic write_scale(input logic [2:0] addr, input logic [5:0] val);
      scale_we = 1'b1; scale_addr = addr; scale_wdata = val;
      @(posedge clk); #1;
      scale_we = 1'b0;
   endtask

   // Offers one op with out_ready=1, returns the result and edges from accept to out_valid.
   task automatic issue_single(input logic [31:0] a, b, c, input logic [2:0] sel,
                               input logic rnd, sat,
                               output logic [31:0] r, output logic o, output int lat);
      drive_op('{a: a, b: b, c: c, sel: sel, round_en: rnd, sat_en: sat});
      out_ready = 1'b1; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = -1; r = '0; o = 1'b0;
      for (int k = 0; k < 10; k++) begin
         if (out_valid) begin
            lat = k; r = result; o = overflow;
            break;
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; #3;
      tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
      tests++; if (result !== 32'd0) begin fails++; $display("FAIL reset_result got %h want 0", result); end
      tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL reset_overflow got %b want 0", overflow); end
      do_reset();
      tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
      for (int i = 0; i < 8; i++) begin
         scale_addr = 3'(i); #1;
         tests++;
         if (scale_rdata !== 6'(i)) begin fails++; $display("FAIL reset_scale[%0d] got %0d want %0d", i, scale_rdata, i); end
      end
   endtask

   task automatic test_basic();
      logic [31:0] r; logic o; int lat;
      issue_single(32'd3, 32'd5, 32'd7, 3'd0, 1'b0, 1'b0, r, o, lat);
      tests++; if (lat !== FXMADD_LATENCY - 1) begin fails++; $display("FAIL basic_latency got %0d edges want %0d", lat, FXMADD_LATENCY - 1); end
      tests++; if (r !== 32'd22) begin fails++; $display("FAIL basic_result got %0d want 22", r); end
      tests++; if (o !== 1'b0) begin fails++; $display("FAIL basic_overflow got %b want 0", o); end
   endtask

   task automatic test_scale();
      logic [31:0] r; logic o; int lat;
      write_scale(3'd2, 6'd2);
      scale_addr = 3'd2; #1;
      tests++; if (scale_rdata !== 6'd2) begin fails++; $display("FAIL scale_readback got %0d want 2", scale_rdata); end
      issue_single(32'h100, 32'h100, 32'd1, 3'd2, 1'b0, 1'b0, r, o, lat);
      tests++; if (r !== 32'h4001) begin fails++; $display("FAIL scale_sel2 got %h want 4001", r); end
      do_reset();
      issue_single(32'h100, 32'h100, 32'd1, 3'd1, 1'b0, 1'b0, r, o, lat);
      tests++; if (r !== 32'h8001) begin fails++; $display("FAIL scale_sel1 got %h want 8001", r); end
   endtask

   task automatic test_round();
      logic [31:0] ta [4] = '{32'd3, 32'd3, 32'hFFFF_FFFD, 32'hFFFF_FFFD};
      logic        tr [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
      logic [31:0] te [4] = '{32'd1, 32'd2, 32'hFFFF_FFFE, 32'hFFFF_FFFF};
      logic [31:0] r; logic o; int lat;
      for (int i = 0; i < 4; i++) begin
         issue_single(ta[i], 32'd1, 32'd0, 3'd1, tr[i], 1'b0, r, o, lat);
         tests++;
         if (r !== te[i]) begin fails++; $display("FAIL round_case%0d got %h want %h", i, r, te[i]); end
      end
   endtask

   task automatic test_sat();
      logic [31:0] ta [3] = '{32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000};
      logic [31:0] tb [3] = '{32'd2, 32'd2, 32'd1};
      logic [31:0] tc [3] = '{32'd0, 32'd0, 32'hFFFF_FFFF};
      logic        ts [3] = '{1'b1, 1'b0, 1'b1};
      logic [31:0] te [3] = '{32'h7FFF_FFFF, 32'hFFFF_FFFE, 32'h8000_0000};
      logic [31:0] r; logic o; int lat;
      for (int i = 0; i < 3; i++) begin
         issue_single(ta[i], tb[i], tc[i], 3'd0, 1'b0, ts[i], r, o, lat);
         tests++; if (r !== te[i]) begin fails++; $display("FAIL sat_case%0d result got %h want %h", i, r, te[i]); end
         tests++; if (o !== 1'b1) begin fails++; $display("FAIL sat_case%0d overflow got %b want 1", i, o); end
      end
   endtask

   task automatic test_back_to_back();
      fxmadd_req_t ops [4];
      logic [31:0] er [4]; logic eo [4];
      do_reset();
      for (int i = 0; i < 4; i++) begin
         ops[i] = '{a: 32'($urandom_range(0, 4000)) - 32'd2000, b: 32'($urandom_range(0, 4000)) - 32'd2000,
                    c: $urandom, sel: 3'($urandom_range(0, 7)), round_en: 1'($urandom), sat_en: 1'($urandom)};
         model(ops[i].a, ops[i].b, ops[i].c, mscale[ops[i].sel], ops[i].round_en, ops[i].sat_en, er[i], eo[i]);
      end
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         drive_op(ops[i]); in_valid = 1'b1;
         @(posedge clk); #1;
      end
      drive_op(ops[3]); #1;
      tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL bp_in_ready_low got %b want 0", in_ready); end
      for (int k = 0; k < 3; k++) begin
         @(posedge clk); #1;
         tests++;
         if (out_valid !== 1'b1 || result !== er[0] || in_ready !== 1'b0)
            begin fails++; $display("FAIL bp_hold cyc%0d valid=%b result=%h in_ready=%b want 1/%h/0", k, out_valid, result, in_ready, er[0]); end
      end
      out_ready = 1'b1; #1;
      for (int j = 0; j < 4; j++) begin
         tests++;
         if (out_valid !== 1'b1 || result !== er[j] || overflow !== eo[j])
            begin fails++; $display("FAIL bp_drain%0d valid=%b result=%h ovf=%b want 1/%h/%b", j, out_valid, result, overflow, er[j], eo[j]); end
         @(posedge clk); #1;
         in_valid = 1'b0;
      end
      tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL bp_empty got valid=%b want 0", out_valid); end
   endtask

   task automatic test_hazard();
      logic [31:0] got [2]; int n = 0;
      do_reset();
      drive_op('{a: 32'h100, b: 32'h100, c: 32'd0, sel: 3'd3, round_en: 1'b0, sat_en: 1'b0});
      in_valid = 1'b1; scale_we = 1'b1; scale_addr = 3'd3; scale_wdata = 6'd0;
      @(posedge clk); #1;
      scale_we = 1'b0;
      @(posedge clk); #1;
      in_valid = 1'b0;
      for (int k = 0; k < 10 && n < 2; k++) begin
         if (out_valid) begin got[n] = result; n++; end
         @(posedge clk); #1;
      end
      tests++; if (n !== 2) begin fails++; $display("FAIL hazard_count got %0d want 2", n); end
      else begin
         tests++; if (got[0] !== 32'h2000) begin fails++; $display("FAIL hazard_old_scale got %h want 2000", got[0]); end
         tests++; if (got[1] !== 32'h10000) begin fails++; $display("FAIL hazard_new_scale got %h want 10000", got[1]); end
      end
   endtask

   task automatic test_reset_midflight();
      int seen = 0;
      out_ready = 1'b1;
      drive_op('{a: 32'd9, b: 32'd9, c: 32'd1, sel: 3'd0, round_en: 1'b0, sat_en: 1'b0});
      in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin @(posedge clk); #1; end
      in_valid = 1'b0;
      tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL midrst_pre_valid got %b want 1", out_valid); end
      rst = 1'b1; #1;
      tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL midrst_valid got %b want 0", out_valid); end
      scale_addr = 3'd3; #1;
      tests++; if (scale_rdata !== 6'd3) begin fails++; $display("FAIL midrst_scale3 got %0d want 3", scale_rdata); end
      @(posedge clk); #1;
      rst = 1'b0;
      for (int k = 0; k < 8; k++) begin
         if (out_valid) seen++;
         @(posedge clk); #1;
      end
      tests++; if (seen !== 0) begin fails++; $display("FAIL midrst_ghost got %0d outputs want 0", seen); end
   endtask

   task automatic test_random();
      logic [31:0] qr [$]; logic qo [$];
      logic [31:0] er, held_r; logic eo, held_o, held = 1'b0, acc, pop;
      do_reset();
      for (int cyc = 0; cyc < 400; cyc++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         mul_op_1  = $urandom_range(0, 1) ? $urandom : 32'($urandom_range(0, 2000)) - 32'd1000;
         mul_op_2  = $urandom_range(0, 1) ? $urandom : 32'($urandom_range(0, 2000)) - 32'd1000;
         add_op    = $urandom;
         scale_sel = 3'($urandom_range(0, 7));
         round_en  = 1'($urandom); sat_en = 1'($urandom);
         out_ready = ($urandom_range(0, 2) != 0);
         scale_we  = ($urandom_range(0, 7) == 0);
         scale_addr = 3'($urandom_range(0, 7)); scale_wdata = 6'($urandom_range(0, 63));
         #1;
         acc = in_valid && in_ready;
         pop = out_valid && out_ready;
         if (held) begin
            tests++;
            if (out_valid !== 1'b1 || result !== held_r || overflow !== held_o)
               begin fails++; $display("FAIL rand_stall_hold cyc%0d valid=%b result=%h want 1/%h", cyc, out_valid, result, held_r); end
         end
         if (pop) begin
            tests++;
            if (qr.size() == 0) begin fails++; $display("FAIL rand_unexpected cyc%0d result=%h want none", cyc, result); end
            else begin
               er = qr.pop_front(); eo = qo.pop_front();
               if (result !== er || overflow !== eo)
                  begin fails++; $display("FAIL rand_result cyc%0d got %h/%b want %h/%b", cyc, result, overflow, er, eo); end
            end
         end
         held = out_valid && !out_ready; held_r = result; held_o = overflow;
         if (acc) begin
            model(mul_op_1, mul_op_2, add_op, mscale[scale_sel], round_en, sat_en, er, eo);
            qr.push_back(er); qo.push_back(eo);
         end
         if (scale_we) mscale[scale_addr] = int'(scale_wdata);
         @(posedge clk); #1;
      end
      in_valid = 1'b0; scale_we = 1'b0; out_ready = 1'b1;
      for (int k = 0; k < 20 && qr.size() > 0; k++) begin
         if (out_valid) begin
            er = qr.pop_front(); eo = qo.pop_front();
            tests++;
            if (result !== er || overflow !== eo)
               begin fails++; $display("FAIL rand_drain got %h/%b want %h/%b", result, overflow, er, eo); end
         end
         @(posedge clk); #1;
      end
      tests++; if (qr.size() != 0) begin fails++; $display("FAIL rand_lost got %0d pending want 0", qr.size()); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_scale();
      test_round();
      test_sat();
      test_back_to_back();
      test_hazard();
      test_reset_midflight();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
